ddr_rd_bridge: RTL and testbench

DDR_RD_BRIDGE -- requirements
Module: ddr_rd_bridge

---
 rtl/ddr_rd_bridge.sv | 180 ++++++++++++++++++
 tb/tb_ddr_rd_bridge.sv | 616 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_bridge.sv
// Read bridge from ddr2pe burst requests to an AXI read master. Read data is buffered in a
// FIFO whose space is reserved at request time, so the R channel never needs back-pressure.
module ddr_rd_bridge #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned MAX_OUT    = 4,
  parameter int unsigned DDR_W      = 64,
  parameter int unsigned DDR_ADDR_W = 32,
  parameter int unsigned BURST_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DDR_ADDR_W-1:0] req_addr,
  input  logic [BURST_W-1:0]    req_size,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [DDR_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DDR_ADDR_W-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DDR_W-1:0]      m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  err,
  output logic                  idle
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  logic                  r_run;
  logic                  r_arvalid;
  logic [DDR_ADDR_W-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [CW-1:0]         r_resv;
  logic [OW-1:0]         r_outs;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_out_valid;
  logic [DDR_W-1:0]      r_out_data;
  logic                  r_err;
  logic [DDR_W-1:0]      r_mem [FIFO_DEPTH];

  logic [31:0]   w_size32;
  logic [31:0]   w_need;
  logic          w_zero;
  logic          w_oversize;
  logic          w_ar_free;
  logic          w_outs_ok;
  logic          w_space_ok;
  logic          w_accept;
  logic          w_issue;
  logic          w_rbeat;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_out_hs;
  logic          w_outs_dec;
  logic [CW-1:0] w_resv_d;
  logic [OW-1:0] w_outs_d;
  logic [CW-1:0] w_cnt_d;

  assign w_size32   = 32'(req_size);
  assign w_need     = 32'(r_resv) + w_size32;
  assign w_zero     = (req_size == '0);
  assign w_oversize = (w_size32 > 32'd256);
  assign w_ar_free  = !r_arvalid | m_arready;
  assign w_outs_ok  = (32'(r_outs) < MAX_OUT);
  // Oversize requests are swallowed with an error, so they must not wait on FIFO space.
  assign w_space_ok = w_oversize | (w_need <= FIFO_DEPTH);

  assign req_ready  = r_run & w_ar_free & w_outs_ok & w_space_ok;
  assign w_accept   = req_valid & req_ready;
  assign w_issue    = w_accept & !w_zero & !w_oversize;

  assign w_rbeat    = m_rvalid & r_run;
  assign w_full     = (32'(r_cnt) == FIFO_DEPTH);
  assign w_empty    = (r_cnt == '0);
  assign w_push     = w_rbeat & !w_full;
  assign w_out_hs   = r_out_valid & out_ready;
  assign w_pop      = !w_empty & (!r_out_valid | out_ready);
  assign w_outs_dec = w_rbeat & m_rlast & (r_outs != '0);

  always_comb begin
    w_resv_d = r_resv;
    if (w_issue) begin
      w_resv_d = w_resv_d + CW'(req_size);
    end
    if (w_out_hs) begin
      w_resv_d = w_resv_d - CW'(1);
    end
  end

  always_comb begin
    w_outs_d = r_outs;
    case ({w_issue, w_outs_dec})
      2'b10:   w_outs_d = r_outs + OW'(1);
      2'b01:   w_outs_d = r_outs - OW'(1);
      default: w_outs_d = r_outs;
    endcase
  end

  always_comb begin
    w_cnt_d = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_d = r_cnt + CW'(1);
      2'b01:   w_cnt_d = r_cnt - CW'(1);
      default: w_cnt_d = r_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run       <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_resv      <= '0;
      r_outs      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_resv <= w_resv_d;
      r_outs <= w_outs_d;
      r_cnt  <= w_cnt_d;

      if (w_issue) begin
        r_arvalid <= 1'b1;
        r_araddr  <= req_addr;
        r_arlen   <= 8'(req_size - BURST_W'(1));
      end else if (m_arready) begin
        r_arvalid <= 1'b0;
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem[r_rd_ptr];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if ((w_accept & w_oversize) | (w_rbeat & w_full) | (w_rbeat & (m_rresp != 2'b00))) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= m_rdata;
    end
  end

  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_run;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err       = r_err;
  assign idle      = (r_outs == '0) & w_empty & !r_arvalid & !r_out_valid;

endmodule

// File: tb/tb_ddr_rd_bridge.sv
// Self-checking bench for ddr_rd_bridge: directed scenarios plus a randomized run against a
// queue-based model of reservations, outstanding bursts and the in-order data stream.
module tb_ddr_rd_bridge;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned MAXO  = 4;
  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 32;
  localparam int unsigned BW    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_size;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic          m_arvalid;
  logic          m_arready;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp;
  logic          m_rlast;
  logic          m_rvalid;
  logic          m_rready;
  logic          err;
  logic          idle;

  int n_vec = 0;
  int n_err = 0;

  ddr_rd_bridge #(
    .FIFO_DEPTH(DEPTH),
    .MAX_OUT   (MAXO),
    .DDR_W     (DW),
    .DDR_ADDR_W(AW),
    .BURST_W   (BW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_addr (req_addr),
    .req_size (req_size),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .m_araddr (m_araddr),
    .m_arlen  (m_arlen),
    .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rdata  (m_rdata),
    .m_rresp  (m_rresp),
    .m_rlast  (m_rlast),
    .m_rvalid (m_rvalid),
    .m_rready (m_rready),
    .err      (err),
    .idle     (idle)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_addr  = '0;
    req_size  = '0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    m_arready = 1'b0;
    m_rdata   = '0;
    m_rresp   = 2'b00;
    m_rlast   = 1'b0;
    m_rvalid  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({idle, req_ready, m_arvalid, out_valid, err, m_rready} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_flags got %b exp 100000",
               {idle, req_ready, m_arvalid, out_valid, err, m_rready});
    end
    n_vec++;
    if ({m_araddr, m_arlen, out_data} !== '0) begin
      n_err++;
      $display("FAIL reset_values got %h/%h/%h exp 0", m_araddr, m_arlen, out_data);
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_size  = BW'(1);
    rst       = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_before_edge got %b exp 0", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_edge got %b exp 1", req_ready);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] d [16];
    do_reset();
    for (int i = 0; i < 16; i++) d[i] = {$urandom(), $urandom()};
    m_arready = 1'b1;
    out_ready = 1'b1;
    req_addr  = 32'h1000;
    req_size  = BW'(16);
    req_valid = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_ready got %b exp 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    #1;
    n_vec++;
    if ({m_arvalid, m_araddr, m_arlen} !== {1'b1, 32'h1000, 8'd15}) begin
      n_err++;
      $display("FAIL basic_ar got %b/%h/%0d exp 1/1000/15", m_arvalid, m_araddr, m_arlen);
    end
    n_vec++;
    if (m_rready !== 1'b1) begin
      n_err++;
      $display("FAIL basic_rready got %b exp 1", m_rready);
    end
    step();
    for (int j = 0; j < 18; j++) begin
      m_rvalid = (j < 16);
      m_rdata  = (j < 16) ? d[j] : '0;
      m_rlast  = (j == 15);
      #1;
      n_vec++;
      if (j < 2) begin
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL basic_latency cycle %0d got valid %b exp 0", j, out_valid);
        end
      end else if (out_valid !== 1'b1 || out_data !== d[j-2]) begin
        n_err++;
        $display("FAIL basic_beat %0d got %b/%h exp 1/%h", j - 2, out_valid, out_data, d[j-2]);
      end
      step();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, idle} !== 2'b01) begin
      n_err++;
      $display("FAIL basic_idle got valid/idle %b exp 01", {out_valid, idle});
    end
  endtask

  task automatic test_fifo_full();
    int  acc;
    int  drained;
    bit  seen;
    do_reset();
    m_arready = 1'b1;
    out_ready = 1'b0;
    req_addr  = 32'h2000;
    req_size  = BW'(32);
    req_valid = 1'b1;
    acc = 0;
    repeat (4) begin
      #1;
      if (req_ready) acc++;
      step();
    end
    n_vec++;
    if (acc != 2) begin
      n_err++;
      $display("FAIL full_accepts got %0d exp 2", acc);
    end
    for (int i = 0; i < 64; i++) begin
      m_rvalid = 1'b1;
      m_rdata  = DW'(i);
      m_rlast  = (i == 31) || (i == 63);
      #1;
      n_vec++;
      if (req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL full_blocked beat %0d got ready %b exp 0", i, req_ready);
      end
      step();
    end
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    out_ready = 1'b1;
    drained   = 0;
    seen      = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      #1;
      if (req_ready === 1'b1) begin
        seen = 1'b1;
        n_vec++;
        if (drained != 32) begin
          n_err++;
          $display("FAIL full_release got drained %0d exp 32", drained);
        end
      end
      if (out_valid === 1'b1) begin
        n_vec++;
        if (out_data !== DW'(drained)) begin
          n_err++;
          $display("FAIL full_order got %h exp %h", out_data, DW'(drained));
        end
        drained++;
      end
      step();
    end
    req_valid = 1'b0;
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL full_timeout got ready 0 after %0d beats exp 1", drained);
    end
  endtask

  task automatic test_max_out();
    int acc;
    do_reset();
    m_arready = 1'b1;
    out_ready = 1'b1;
    req_size  = BW'(1);
    req_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_addr = 32'h3000 + 32'(c * 64);
      #1;
      if (req_ready) acc++;
      step();
    end
    n_vec++;
    if (acc != 4) begin
      n_err++;
      $display("FAIL maxout_accepts got %0d exp 4", acc);
    end
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    m_rdata  = {$urandom(), $urandom()};
    #1;
    n_vec++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL maxout_stall got %b exp 0", req_ready);
    end
    step();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL maxout_release got %b exp 1", req_ready);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_ar_stall();
    do_reset();
    m_arready = 1'b0;
    req_addr  = 32'h4000;
    req_size  = BW'(8);
    req_valid = 1'b1;
    #1;
    step();
    req_addr = 32'h5000;
    req_size = BW'(3);
    repeat (5) begin
      #1;
      n_vec++;
      if ({req_ready, m_arvalid, m_araddr, m_arlen} !== {1'b0, 1'b1, 32'h4000, 8'd7}) begin
        n_err++;
        $display("FAIL arstall_hold got %b/%b/%h/%0d exp 0/1/4000/7",
                 req_ready, m_arvalid, m_araddr, m_arlen);
      end
      step();
    end
    m_arready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL arstall_ready got %b exp 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    #1;
    n_vec++;
    if ({m_arvalid, m_araddr, m_arlen} !== {1'b1, 32'h5000, 8'd2}) begin
      n_err++;
      $display("FAIL arstall_next got %b/%h/%0d exp 1/5000/2", m_arvalid, m_araddr, m_arlen);
    end
    step();
  endtask

  task automatic test_err();
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    d0 = {$urandom(), $urandom()};
    d1 = {$urandom(), $urandom()};
    do_reset();
    m_arready = 1'b1;
    out_ready = 1'b1;
    req_addr  = 32'h6000;
    req_size  = BW'(2);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    m_rvalid = 1'b1;
    m_rdata  = d0;
    m_rresp  = 2'b10;
    step();
    m_rdata  = d1;
    m_rresp  = 2'b00;
    m_rlast  = 1'b1;
    #1;
    n_vec++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL err_set got %b exp 1", err);
    end
    step();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_data} !== {1'b1, d0}) begin
      n_err++;
      $display("FAIL err_data0 got %b/%h exp 1/%h", out_valid, out_data, d0);
    end
    step();
    #1;
    n_vec++;
    if ({out_valid, out_data} !== {1'b1, d1}) begin
      n_err++;
      $display("FAIL err_data1 got %b/%h exp 1/%h", out_valid, out_data, d1);
    end
    step();
    req_size  = '0;
    req_valid = 1'b1;
    #1;
    n_vec++;
    if ({err, idle, req_ready} !== 3'b111) begin
      n_err++;
      $display("FAIL err_sticky got err/idle/ready %b exp 111", {err, idle, req_ready});
    end
    step();
    req_valid = 1'b0;
    #1;
    n_vec++;
    if ({err, m_arvalid, idle} !== 3'b101) begin
      n_err++;
      $display("FAIL size0_noar got err/arvalid/idle %b exp 101", {err, m_arvalid, idle});
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear got %b exp 0", err);
    end
    #1;
    rst = 1'b0;
    step();
    req_size  = BW'(300);
    req_valid = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL oversize_ready got %b exp 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    #1;
    n_vec++;
    if ({err, m_arvalid, idle} !== 3'b101) begin
      n_err++;
      $display("FAIL oversize got err/arvalid/idle %b exp 101", {err, m_arvalid, idle});
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d [4];
    do_reset();
    for (int i = 0; i < 4; i++) d[i] = {$urandom(), $urandom()};
    m_arready = 1'b1;
    out_ready = 1'b0;
    req_size  = BW'(4);
    req_addr  = 32'h7000;
    req_valid = 1'b1;
    step();
    req_addr = 32'h7100;
    step();
    req_valid = 1'b0;
    step();
    m_rvalid = 1'b1;
    m_rdata  = {$urandom(), $urandom()};
    step();
    m_rvalid = 1'b0;
    step();
    #1;
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_pre got valid %b exp 1", out_valid);
    end
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({out_valid, m_arvalid, idle, err, req_ready, m_rready} !== 6'b001000) begin
      n_err++;
      $display("FAIL midrst_flags got %b exp 001000",
               {out_valid, m_arvalid, idle, err, req_ready, m_rready});
    end
    n_vec++;
    if ({out_data, m_araddr, m_arlen} !== '0) begin
      n_err++;
      $display("FAIL midrst_values got %h/%h/%h exp 0", out_data, m_araddr, m_arlen);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    req_addr  = 32'h8000;
    req_size  = BW'(4);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    #1;
    n_vec++;
    if ({m_arvalid, m_araddr, m_arlen} !== {1'b1, 32'h8000, 8'd3}) begin
      n_err++;
      $display("FAIL midrst_ar got %b/%h/%0d exp 1/8000/3", m_arvalid, m_araddr, m_arlen);
    end
    step();
    for (int j = 0; j < 6; j++) begin
      m_rvalid = (j < 4);
      m_rdata  = (j < 4) ? d[j] : '0;
      m_rlast  = (j == 3);
      #1;
      if (j >= 2) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== d[j-2]) begin
          n_err++;
          $display("FAIL midrst_beat %0d got %b/%h exp 1/%h", j - 2, out_valid, out_data, d[j-2]);
        end
      end
      step();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    step();
    step();
    #1;
    n_vec++;
    if (idle !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_idle got %b exp 1", idle);
    end
  endtask

  task automatic test_random();
    int            m_resv;
    int            m_outs;
    bit            m_ar_pend;
    logic [AW-1:0] m_ar_addr;
    logic [7:0]    m_ar_len;
    int            burst_q [$];
    logic [DW-1:0] data_q [$];
    bit            exp_ready;
    bit            prev_stall;
    do_reset();
    m_resv     = 0;
    m_outs     = 0;
    m_ar_pend  = 1'b0;
    m_ar_addr  = '0;
    m_ar_len   = '0;
    prev_stall = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit drain;
      drain     = (cyc >= 2700);
      req_valid = drain ? 1'b0 : 1'($urandom_range(0, 1));
      req_size  = BW'($urandom_range(0, 20));
      req_addr  = $urandom();
      m_arready = ($urandom_range(0, 3) != 0);
      out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (burst_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        m_rvalid = 1'b1;
        m_rdata  = {$urandom(), $urandom()};
        m_rlast  = (burst_q[0] == 1);
      end else begin
        m_rvalid = 1'b0;
        m_rdata  = '0;
        m_rlast  = 1'b0;
      end
      #1;
      exp_ready = (!m_ar_pend || m_arready) && (m_outs < int'(MAXO)) &&
                  (m_resv + int'(req_size) <= int'(DEPTH));
      n_vec++;
      if (req_ready !== exp_ready) begin
        n_err++;
        $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, req_ready, exp_ready);
      end
      n_vec++;
      if (m_arvalid !== m_ar_pend ||
          (m_ar_pend && {m_araddr, m_arlen} !== {m_ar_addr, m_ar_len})) begin
        n_err++;
        $display("FAIL rnd_ar cyc %0d got %b/%h/%0d exp %b/%h/%0d", cyc, m_arvalid, m_araddr,
                 m_arlen, m_ar_pend, m_ar_addr, m_ar_len);
      end
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1) begin
          n_err++;
          $display("FAIL rnd_hold cyc %0d got valid %b exp 1", cyc, out_valid);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_vec++;
        if (data_q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_data cyc %0d got %h exp none", cyc, out_data);
        end else begin
          if (out_data !== data_q[0]) begin
            n_err++;
            $display("FAIL rnd_data cyc %0d got %h exp %h", cyc, out_data, data_q[0]);
          end
          void'(data_q.pop_front());
        end
        m_resv--;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      if (m_ar_pend && m_arready) begin
        burst_q.push_back(int'(m_ar_len) + 1);
        m_ar_pend = 1'b0;
      end
      if (req_valid && exp_ready && req_size != '0) begin
        m_ar_pend = 1'b1;
        m_ar_addr = req_addr;
        m_ar_len  = 8'(int'(req_size) - 1);
        m_resv    = m_resv + int'(req_size);
        m_outs++;
      end
      if (m_rvalid) begin
        data_q.push_back(m_rdata);
        burst_q[0] = burst_q[0] - 1;
        if (burst_q[0] == 0) begin
          void'(burst_q.pop_front());
          m_outs--;
        end
      end
      step();
    end
    idle_inputs();
    step();
    #1;
    n_vec++;
    if (idle !== (data_q.size() == 0 && burst_q.size() == 0 && !m_ar_pend)) begin
      n_err++;
      $display("FAIL rnd_end_idle got %b exp %b (%0d beats, %0d bursts left)", idle,
               (data_q.size() == 0 && burst_q.size() == 0 && !m_ar_pend), data_q.size(),
               burst_q.size());
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_fifo_full();
    test_max_out();
    test_ar_stall();
    test_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
